// File: rtl/encod_matriz_scan_if.sv
// rtl/encod_matriz_scan_if.sv - matrix lines in, encoded key result with valid/ack handshake out
interface encod_matriz_scan_if;
   logic [5:0] MLed_in;
   logic       ack;
   logic       valid;
   logic [2:0] code1;
   logic [2:0] code2;
   logic       err;

   modport master (
      output MLed_in,
      output ack,
      input  valid,
      input  code1,
      input  code2,
      input  err
   );

   modport slave (
      input  MLed_in,
      input  ack,
      output valid,
      output code1,
      output code2,
      output err
   );
endinterface

// File: rtl/encod_matriz_scan.sv
// rtl/encod_matriz_scan.sv - debounced matrix line scanner producing up to two key codes plus overflow flag
module encod_matriz_scan #(
   parameter int DEB_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   encod_matriz_scan_if.slave   bus
);

   localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
   localparam logic [5:0] ALL_HIGH = 6'b111111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DEB,
      S_SCAN,
      S_PRESENT,
      S_RELEASE
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] sync1_q, sync2_q;
   logic [5:0] snap_q, snap_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [2:0] code1_q, code1_d;
   logic [2:0] code2_q, code2_d;
   logic       err_q, err_d;

   // Line index to key code; 000 and 010 are never a line code, so 000 marks "empty".
   function automatic logic [2:0] line_code(input logic [2:0] idx);
      case (idx)
         3'd0:    line_code = 3'b001;
         3'd1:    line_code = 3'b011;
         3'd2:    line_code = 3'b100;
         3'd3:    line_code = 3'b101;
         3'd4:    line_code = 3'b110;
         3'd5:    line_code = 3'b111;
         default: line_code = 3'b000;
      endcase
   endfunction

   // Two-flop synchronizer; idles high so reset looks like "no key pressed".
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= ALL_HIGH;
         sync2_q <= ALL_HIGH;
      end else begin
         sync1_q <= bus.MLed_in;
         sync2_q <= sync1_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         snap_q  <= ALL_HIGH;
         cnt_q   <= 8'd0;
         idx_q   <= 3'd0;
         code1_q <= 3'b000;
         code2_q <= 3'b000;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         code1_q <= code1_d;
         code2_q <= code2_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: debounce, serial scan of the snapshot, present/handshake, release wait.
   always_comb begin
      logic [2:0] c1, c2;
      logic       e;
      state_d = state_q;
      snap_d  = snap_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      code1_d = code1_q;
      code2_d = code2_q;
      err_d   = err_q;
      c1      = code1_q;
      c2      = code2_q;
      e       = err_q;

      case (state_q)
         S_IDLE: begin
            if (sync2_q != ALL_HIGH) begin
               snap_d  = sync2_q;
               cnt_d   = 8'd0;
               state_d = S_DEB;
            end
         end

         S_DEB: begin
            if (sync2_q == ALL_HIGH) begin
               state_d = S_IDLE;
            end else if (sync2_q != snap_q) begin
               snap_d = sync2_q;
               cnt_d  = 8'd0;
            end else if (cnt_q == DEB_LAST) begin
               idx_d   = 3'd0;
               state_d = S_SCAN;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         S_SCAN: begin
            // First scan cycle starts from a cleared result; an empty code slot means "not yet filled".
            if (idx_q == 3'd0) begin
               c1 = 3'b000;
               c2 = 3'b000;
               e  = 1'b0;
            end
            if (!snap_q[idx_q]) begin
               if (c1 == 3'b000)      c1 = line_code(idx_q);
               else if (c2 == 3'b000) c2 = line_code(idx_q);
               else                   e  = 1'b1;
            end
            code1_d = c1;
            code2_d = c2;
            err_d   = e;
            if (idx_q == 3'd5) begin
               state_d = S_PRESENT;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end

         S_PRESENT: begin
            if (bus.ack) begin
               cnt_d   = 8'd0;
               state_d = S_RELEASE;
            end
         end

         S_RELEASE: begin
            if (sync2_q != ALL_HIGH) begin
               cnt_d = 8'd0;
            end else if (cnt_q == DEB_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.valid = (state_q == S_PRESENT);
   assign bus.code1 = code1_q;
   assign bus.code2 = code2_q;
   assign bus.err   = err_q;

endmodule

// File: doc/encod_matriz_scan.md
ENCOD_MATRIZ_SCAN -- requirements
Module: encod_matriz_scan

Interface
REQ-001 Parameter: DEB_CYCLES, default 4, debounce length in clock cycles; legal range 1..255.
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 MLed_in  input  6  active-low, asynchronous matrix lines: bit0=MLed0, bit1=MLed2, bit2=MLed3, bit3=MLed4, bit4=MLed5, bit5=MLed6.
REQ-006 ack  input  1  consumer acknowledge; sampled only while valid=1.
REQ-007 valid  output  1  code1/code2/err hold a new result.
REQ-008 code1  output  3  {MSB1,B1,LSB1} code of the lowest-index low line.
REQ-009 code2  output  3  {MSB2,B2,LSB2} code of the second-lowest low line; 000 if none.
REQ-010 err  output  1  three or more lines were low in the captured pattern.

Function
REQ-011 Line-to-code map: bit0->001, bit1->011, bit2->100, bit3->101, bit4->110, bit5->111; codes 000 (none) and 010 are never produced for a line.
REQ-012 MLed_in passes through a 2-flop synchronizer per bit; all logic below uses the synchronized vector (sync); latency pin->sync = 2 cycles.
REQ-013 FSM states: IDLE, DEB, SCAN, PRESENT, RELEASE.
REQ-014 IDLE: when sync != 6'b111111, capture snap<=sync, cnt<=0, go DEB.
REQ-015 DEB: if sync == 6'b111111 go IDLE; else if sync != snap, snap<=sync, cnt<=0; else if cnt == DEB_CYCLES-1 go SCAN; else cnt<=cnt+1.
REQ-016 SCAN: exactly 6 cycles, index 0..5 ascending, one bit of snap per cycle; first low bit loads code1, second loads code2, third or later sets err; live sync ignored.
REQ-017 PRESENT: valid=1; code1, code2, err held stable; sync changes ignored.
REQ-018 Latency: valid rises DEB_CYCLES+7 cycles after the pattern first appears on sync (DEB_CYCLES+9 after the pin change) when the pattern is held stable.
REQ-019 Handshake: ack=1 in any PRESENT cycle (including the first) -> valid=0 next cycle, go RELEASE; code1/code2/err keep values until the next SCAN begins.
REQ-020 ack while valid=0 has no effect.
REQ-021 RELEASE: go IDLE after sync == 6'b111111 for DEB_CYCLES consecutive cycles; any low line restarts that count.
REQ-022 A key held through ack produces no second result until released per REQ-021.
REQ-023 Debounce counter is 8 bits; no wrap-around occurs because exit happens at DEB_CYCLES-1.
REQ-024 SCAN clears code1, code2, err on its first cycle before loading.

Reset
REQ-025 rst_n=0 at a rising edge, in any state: next cycle state=IDLE, valid=0, code1=000, code2=000, err=0, cnt=0, snap=6'b111111, synchronizer flops=1.
REQ-026 Reset overrides ack and every line input in the same cycle; an in-flight SCAN or PRESENT result is discarded.

Verification
REQ-027 DEB_CYCLES=4, bit2 low held -> valid rises 13 cycles after pin change, code1=100, code2=000, err=0.
REQ-028 bit0 and bit5 low -> code1=001, code2=111, err=0.
REQ-029 bits 1, 3, 4 low -> code1=011, code2=101, err=1.
REQ-030 bit3 low for 3 cycles only (DEB_CYCLES=4) -> valid never asserts; FSM returns IDLE.
REQ-031 Result present, ack held 0 for 20 cycles while lines change -> valid and codes constant; ack=1 -> valid=0 next cycle; new press after 4 all-high cycles is detected.
REQ-032 rst_n=0 during SCAN -> next cycle valid=0, code1=code2=000, err=0, state IDLE.
